// File: rtl/rv32i_types.sv
// Shared RV32I type definitions.
//
// Holds the word type, the pipeline control word, the load/store funct3
// encodings, the memory-access-stage FSM states and the MA/WB register
// layout. Every RTL file that needs these types imports this package.
package rv32i_types;

    typedef logic [31:0] rv32i_word;

    // Control word carried down the pipeline. The MA stage looks only at
    // mem_read and mem_write. The remaining fields ride through to WB.
    typedef struct packed {
        logic       load_regfile;
        logic [3:0] regfilemux_sel;
        logic       mem_read;
        logic       mem_write;
    } rv32i_control_word;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    // WAIT: the request is outstanding and the cache has not answered yet.
    // HOLD: the access is complete, but the downstream register is frozen.
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        HOLD = 2'b10
    } ma_state_t;

    // Layout of the MA/WB pipeline register.
    typedef struct packed {
        rv32i_control_word ctrl;
        rv32i_word         instruction;
        rv32i_word         pc;
        rv32i_word         alu;
        rv32i_word         mem_rdata;
        logic              br_en;
    } ma_wb_t;

endpackage

// File: rtl/load_align.sv
// Load data alignment and extension.
//
// This block is purely combinational. It shifts the addressed bytes of a
// 32-bit read word down to bit 0. It then sign-extends or zero-extends the
// result according to the load funct3. Any load path can reuse it, cached or
// not.
//
// Ports:
//   rdata   in  32  raw word returned by memory
//   offset  in  2   byte offset of the access within the word
//   funct3  in  3   load type (lb/lh/lw/lbu/lhu)
//   result  out 32  aligned, extended load value
module load_align
    import rv32i_types::*;
(
    input  logic [31:0]  rdata,
    input  logic [1:0]   offset,
    input  load_funct3_t funct3,
    output logic [31:0]  result
);

    logic [31:0] shifted;

    // A halfword at offset 3 keeps only the bytes inside the word. The upper
    // byte reads as zero and no second access is made.
    assign shifted = rdata >> {offset, 3'b000};

    always_comb begin
        // NOTE: a default assignment comes before the case. Without it, any
        // funct3 value left out of the case would keep the old result, and
        // synthesis would infer a latch.
        result = shifted;
        case (funct3)
            lb:      result = {{24{shifted[7]}}, shifted[7:0]};
            lbu:     result = {24'h0, shifted[7:0]};
            lh:      result = {{16{shifted[15]}}, shifted[15:0]};
            lhu:     result = {16'h0, shifted[15:0]};
            default: result = shifted;
        endcase
    end

endmodule

// File: rtl/memory_access_stage.sv
// RV32I pipeline memory-access (MA) stage.
//
// This stage takes the EX/MA register contents and performs the data-cache
// request/response handshake. It aligns store data and extracts load data.
// It stalls the upstream pipeline while an access is outstanding. Results are
// registered into the MA/WB register.
//
// Ports:
//   clk, rst                  clock; synchronous active-low reset
//   PC_in, instruction_in     instruction in MA (funct3 = instruction_in[14:12])
//   alu_in                    effective address or ALU result
//   rs2_in                    unaligned store data
//   br_en_in                  comparator result, passed through
//   mem_byte_enable_in        byte lanes computed in EX
//   ctrl_word_in              control word (mem_read / mem_write used here)
//   stall_in                  downstream freeze; MA/WB holds while high
//   data_rdata, data_resp     cache read data and single-cycle completion
//   data_read, data_write     cache requests (mutually exclusive)
//   data_addr, data_mbe       word address and byte enables
//   data_wdata                lane-aligned store data
//   MA_stall                  freezes everything upstream of MA
//   *_out                     MA/WB pipeline register
module memory_access_stage
    import rv32i_types::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       PC_in,
    input  logic [31:0]       instruction_in,
    input  logic [31:0]       alu_in,
    input  logic [31:0]       rs2_in,
    input  logic              br_en_in,
    input  logic [3:0]        mem_byte_enable_in,
    input  rv32i_control_word ctrl_word_in,
    input  logic              stall_in,
    input  logic [31:0]       data_rdata,
    input  logic              data_resp,
    output logic              data_read,
    output logic              data_write,
    output logic [31:0]       data_addr,
    output logic [3:0]        data_mbe,
    output logic [31:0]       data_wdata,
    output logic              MA_stall,
    output rv32i_control_word ctrl_word_out,
    output logic [31:0]       instruction_out,
    output logic [31:0]       PC_out,
    output logic [31:0]       alu_out,
    output logic [31:0]       mem_rdata_out,
    output logic              br_en_out
);

    ma_state_t    state;
    logic [31:0]  hold_buf;
    ma_wb_t       ma_wb;
    ma_wb_t       wb_next;

    logic         mem_op;
    logic         is_load;
    logic         requesting;
    load_funct3_t load_funct3;
    logic [31:0]  load_word;
    logic [31:0]  mem_result;

    assign mem_op     = ctrl_word_in.mem_read | ctrl_word_in.mem_write;
    // mem_write wins when a malformed control word sets both bits.
    assign is_load    = ctrl_word_in.mem_read & ~ctrl_word_in.mem_write;
    // In HOLD the access has already completed, so no request goes out.
    assign requesting = rst & (state != HOLD);

    assign data_read  = requesting & is_load;
    assign data_write = requesting & ctrl_word_in.mem_write;
    assign data_addr  = {alu_in[31:2], 2'b00};
    assign data_mbe   = mem_byte_enable_in;
    assign data_wdata = rs2_in << {alu_in[1:0], 3'b000};

    // The response cycle does not stall. The result goes into MA/WB on that
    // same edge.
    assign MA_stall   = (state != HOLD) & mem_op & ~data_resp;

    assign load_funct3 = load_funct3_t'(instruction_in[14:12]);

    load_align u_load_align (
        .rdata  (data_rdata),
        .offset (alu_in[1:0]),
        .funct3 (load_funct3),
        .result (load_word)
    );

    // Stores and non-memory ops write zero into mem_rdata_out.
    assign mem_result = is_load ? load_word : 32'h0;

    // In HOLD the cache data has gone away, so the buffered result is used.
    always_comb begin
        wb_next.ctrl        = ctrl_word_in;
        wb_next.instruction = instruction_in;
        wb_next.pc          = PC_in;
        wb_next.alu         = alu_in;
        wb_next.mem_rdata   = (state == HOLD) ? hold_buf : mem_result;
        wb_next.br_en       = br_en_in;
    end

    // NOTE: every register in this block is assigned with <=. All flops then
    // update from values sampled before the edge, so the result does not
    // depend on the order of the statements.
    always_ff @(posedge clk) begin
        if (!rst) begin
            // NOTE: the hold buffer is reset along with the control state.
            // It is a single word, and clearing it means a stale load value
            // can never reach WB after a reset.
            state    <= IDLE;
            hold_buf <= '0;
            ma_wb    <= '0;
        end else begin
            case (state)
                IDLE, WAIT: begin
                    if (!mem_op) begin
                        if (!stall_in) ma_wb <= wb_next;
                        state <= IDLE;
                    end else if (!data_resp) begin
                        state <= WAIT;
                    end else if (stall_in) begin
                        hold_buf <= mem_result;
                        state    <= HOLD;
                    end else begin
                        ma_wb <= wb_next;
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    if (!stall_in) begin
                        ma_wb <= wb_next;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ctrl_word_out   = ma_wb.ctrl;
    assign instruction_out = ma_wb.instruction;
    assign PC_out          = ma_wb.pc;
    assign alu_out         = ma_wb.alu;
    assign mem_rdata_out   = ma_wb.mem_rdata;
    assign br_en_out       = ma_wb.br_en;

endmodule

// File: tb/tb_memory_access_stage.sv
// Self-checking bench for memory_access_stage.
//
// Inputs are driven on the falling edge. Combinational outputs are sampled
// 1 ns later. Registered outputs are sampled on the following falling edge.
module tb_memory_access_stage;
    import rv32i_types::*;

    logic              clk = 1'b0;
    logic              rst;
    logic [31:0]       PC_in, instruction_in, alu_in, rs2_in;
    logic              br_en_in;
    logic [3:0]        mem_byte_enable_in;
    rv32i_control_word ctrl_word_in;
    logic              stall_in;
    logic [31:0]       data_rdata;
    logic              data_resp;
    logic              data_read, data_write;
    logic [31:0]       data_addr, data_wdata;
    logic [3:0]        data_mbe;
    logic              MA_stall;
    rv32i_control_word ctrl_word_out;
    logic [31:0]       instruction_out, PC_out, alu_out, mem_rdata_out;
    logic              br_en_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    memory_access_stage dut (
        .clk                (clk),
        .rst                (rst),
        .PC_in              (PC_in),
        .instruction_in     (instruction_in),
        .alu_in             (alu_in),
        .rs2_in             (rs2_in),
        .br_en_in           (br_en_in),
        .mem_byte_enable_in (mem_byte_enable_in),
        .ctrl_word_in       (ctrl_word_in),
        .stall_in           (stall_in),
        .data_rdata         (data_rdata),
        .data_resp          (data_resp),
        .data_read          (data_read),
        .data_write         (data_write),
        .data_addr          (data_addr),
        .data_mbe           (data_mbe),
        .data_wdata         (data_wdata),
        .MA_stall           (MA_stall),
        .ctrl_word_out      (ctrl_word_out),
        .instruction_out    (instruction_out),
        .PC_out             (PC_out),
        .alu_out            (alu_out),
        .mem_rdata_out      (mem_rdata_out),
        .br_en_out          (br_en_out)
    );

    // Reference load value, computed arithmetically from the load rules.
    function automatic logic [31:0] ref_load(input logic [31:0] word, input int off,
                                             input logic [2:0] f3);
        int unsigned v;
        int          s;
        v = word >> (8 * off);
        case (f3)
            3'b000: begin s = int'(v % 256);   if (s >= 128)   s -= 256;   return s; end
            3'b100: return v % 256;
            3'b001: begin s = int'(v % 65536); if (s >= 32768) s -= 65536; return s; end
            3'b101: return v % 65536;
            default: return v;
        endcase
    endfunction

    function automatic rv32i_control_word mk_ctrl(input logic rd, input logic wr);
        rv32i_control_word c;
        c                = '0;
        c.load_regfile   = rd | ~wr;
        c.regfilemux_sel = 4'($urandom_range(0, 15));
        c.mem_read       = rd;
        c.mem_write      = wr;
        return c;
    endfunction

    task automatic drive_op(input logic [31:0] pc, input logic [2:0] f3,
                            input logic [31:0] addr, input logic [31:0] rs2,
                            input logic [3:0] mbe, input logic rd, input logic wr);
        logic [31:0] instr;
        instr              = $urandom;
        instr[14:12]       = f3;
        PC_in              = pc;
        instruction_in     = instr;
        alu_in             = addr;
        rs2_in             = rs2;
        br_en_in           = 1'($urandom_range(0, 1));
        mem_byte_enable_in = mbe;
        ctrl_word_in       = mk_ctrl(rd, wr);
    endtask

    task automatic drive_bubble();
        PC_in              = $urandom;
        instruction_in     = $urandom;
        alu_in             = $urandom;
        rs2_in             = $urandom;
        br_en_in           = 1'($urandom_range(0, 1));
        mem_byte_enable_in = 4'($urandom_range(0, 15));
        ctrl_word_in       = '0;
    endtask

    task automatic test_reset();
        rst = 1'b0; stall_in = 1'b0;
        drive_op(32'h100, 3'b010, 32'h40, 32'h0, 4'hF, 1'b1, 1'b0);
        data_resp = 1'b1; data_rdata = 32'hDEAD_BEEF;
        #1;
        n_checks++;
        if ({data_read, data_write} !== 2'b00) begin
            n_fail++; $display("FAIL reset_req: read/write=%b, expected 00", {data_read, data_write});
        end
        @(negedge clk); @(negedge clk);
        n_checks++;
        if ({ctrl_word_out, instruction_out, PC_out, alu_out, mem_rdata_out, br_en_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_regs: ctrl=%h instr=%h pc=%h alu=%h rdata=%h br=%b, expected all 0",
                     ctrl_word_out, instruction_out, PC_out, alu_out, mem_rdata_out, br_en_out);
        end
        rst = 1'b1; data_resp = 1'b0; drive_bubble();
        @(negedge clk);
    endtask

    task automatic test_lb_wait();
        int   reads = 0, stalls = 0;
        logic addr_ok = 1'b1;
        drive_op(32'h400, 3'b000, 32'h1003, $urandom, 4'b1000, 1'b1, 1'b0);
        stall_in = 1'b0;
        for (int k = 0; k < 3; k++) begin
            data_resp  = (k == 2);
            data_rdata = (k == 2) ? 32'h80FF_0000 : $urandom;
            #1;
            reads  += int'(data_read);
            stalls += int'(MA_stall);
            if (data_addr !== 32'h1000 || data_write !== 1'b0) addr_ok = 1'b0;
            @(negedge clk);
        end
        data_resp = 1'b0; drive_bubble();
        n_checks++;
        if (reads != 3) begin n_fail++; $display("FAIL lb_read_cycles: got %0d, expected 3", reads); end
        n_checks++;
        if (stalls != 2) begin n_fail++; $display("FAIL lb_stall_cycles: got %0d, expected 2", stalls); end
        n_checks++;
        if (!addr_ok) begin n_fail++; $display("FAIL lb_addr: data_addr/data_write wrong, expected 0x1000/0"); end
        n_checks++;
        if (mem_rdata_out !== 32'hFFFF_FF80) begin
            n_fail++; $display("FAIL lb_rdata: got %h, expected ffffff80", mem_rdata_out);
        end
        n_checks++;
        if (alu_out !== 32'h1003 || PC_out !== 32'h400) begin
            n_fail++; $display("FAIL lb_regs: alu=%h pc=%h, expected 1003 400", alu_out, PC_out);
        end
    endtask

    task automatic test_sh_store();
        logic ok = 1'b1;
        drive_op(32'h500, 3'b001, 32'h2002, 32'h0000_BEEF, 4'b1100, 1'b0, 1'b1);
        for (int k = 0; k < 2; k++) begin
            data_resp = (k == 1); data_rdata = $urandom;
            #1;
            if (data_write !== 1'b1 || data_read !== 1'b0 || data_wdata !== 32'hBEEF_0000 ||
                data_mbe !== 4'b1100 || data_addr !== 32'h2000) begin
                ok = 1'b0;
                $display("  sh cycle %0d: wr=%b rd=%b wdata=%h mbe=%b addr=%h",
                         k, data_write, data_read, data_wdata, data_mbe, data_addr);
            end
            @(negedge clk);
        end
        data_resp = 1'b0; drive_bubble();
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL sh_request: expected wr=1 rd=0 wdata=beef0000 mbe=1100 addr=2000"); end
        n_checks++;
        if (mem_rdata_out !== 32'h0 || alu_out !== 32'h2002) begin
            n_fail++; $display("FAIL sh_regs: rdata=%h alu=%h, expected 0 2002", mem_rdata_out, alu_out);
        end
    endtask

    task automatic test_lhu_hold();
        int reads_after = 0, stalls_after = 0;
        drive_op(32'h600, 3'b101, 32'h3006, $urandom, 4'b1100, 1'b1, 1'b0);
        stall_in = 1'b1; data_resp = 1'b1; data_rdata = 32'hF00D_1234;
        #1;
        n_checks++;
        if (data_read !== 1'b1 || MA_stall !== 1'b0) begin
            n_fail++; $display("FAIL lhu_resp_cycle: read=%b stall=%b, expected 1 0", data_read, MA_stall);
        end
        @(negedge clk);
        data_resp = 1'b0;
        for (int k = 0; k < 2; k++) begin
            stall_in = (k == 0); data_rdata = $urandom;
            #1;
            reads_after  += int'(data_read | data_write);
            stalls_after += int'(MA_stall);
            @(negedge clk);
        end
        drive_bubble();
        n_checks++;
        if (reads_after != 0 || stalls_after != 0) begin
            n_fail++; $display("FAIL lhu_hold_req: requests=%0d stalls=%0d, expected 0 0", reads_after, stalls_after);
        end
        n_checks++;
        if (mem_rdata_out !== 32'h0000_F00D || alu_out !== 32'h3006) begin
            n_fail++; $display("FAIL lhu_hold_rdata: rdata=%h alu=%h, expected 0000f00d 3006", mem_rdata_out, alu_out);
        end
    endtask

    task automatic test_alu_op();
        logic [31:0] held_alu;
        drive_op(32'h700, 3'b000, 32'h55, $urandom, 4'hF, 1'b0, 1'b0);
        br_en_in = 1'b1; stall_in = 1'b0; data_resp = 1'b0;
        #1;
        n_checks++;
        if ({data_read, data_write, MA_stall} !== 3'b000) begin
            n_fail++; $display("FAIL alu_no_req: rd/wr/stall=%b, expected 000", {data_read, data_write, MA_stall});
        end
        @(negedge clk);
        n_checks++;
        if (alu_out !== 32'h55 || PC_out !== 32'h700 || br_en_out !== 1'b1 || mem_rdata_out !== 32'h0) begin
            n_fail++; $display("FAIL alu_regs: alu=%h pc=%h br=%b rdata=%h, expected 55 700 1 0",
                               alu_out, PC_out, br_en_out, mem_rdata_out);
        end
        // While stall_in is high, the MA/WB register must keep the add result.
        held_alu = 32'h55;
        drive_op(32'h704, 3'b000, 32'hAA, $urandom, 4'hF, 1'b0, 1'b0);
        stall_in = 1'b1;
        @(negedge clk);
        n_checks++;
        if (alu_out !== held_alu || PC_out !== 32'h700) begin
            n_fail++; $display("FAIL stall_hold: alu=%h pc=%h, expected 55 700", alu_out, PC_out);
        end
        stall_in = 1'b0;
        @(negedge clk);
        n_checks++;
        if (alu_out !== 32'hAA) begin n_fail++; $display("FAIL stall_release: alu=%h, expected aa", alu_out); end
        drive_bubble();
        @(negedge clk);
    endtask

    task automatic test_reset_mid_access();
        drive_op(32'h800, 3'b010, 32'h4000, $urandom, 4'hF, 1'b1, 1'b0);
        stall_in = 1'b0; data_resp = 1'b0;
        @(negedge clk);
        rst = 1'b0; data_resp = 1'b1; data_rdata = $urandom;
        #1;
        n_checks++;
        if (data_read !== 1'b0) begin n_fail++; $display("FAIL rst_wait_read: got %b, expected 0", data_read); end
        @(negedge clk);
        n_checks++;
        if ({ctrl_word_out, instruction_out, PC_out, alu_out, mem_rdata_out, br_en_out} !== '0) begin
            n_fail++; $display("FAIL rst_wait_regs: pc=%h alu=%h rdata=%h, expected all 0",
                               PC_out, alu_out, mem_rdata_out);
        end
        rst = 1'b1; drive_bubble(); data_resp = 1'b1; data_rdata = $urandom;
        #1;
        n_checks++;
        if ({data_read, MA_stall} !== 2'b00) begin
            n_fail++; $display("FAIL rst_late_resp_req: rd/stall=%b, expected 00", {data_read, MA_stall});
        end
        @(negedge clk);
        data_resp = 1'b0;
        n_checks++;
        if (mem_rdata_out !== 32'h0) begin n_fail++; $display("FAIL rst_late_resp: rdata=%h, expected 0", mem_rdata_out); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] w1 = 32'h1111_2222, w2 = 32'h3333_4444;
        stall_in = 1'b0;
        drive_op(32'h900, 3'b010, 32'h5000, $urandom, 4'hF, 1'b1, 1'b0);
        data_resp = 1'b1; data_rdata = w1;
        #1;
        n_checks++;
        if (data_read !== 1'b1 || MA_stall !== 1'b0) begin
            n_fail++; $display("FAIL b2b_first: rd=%b stall=%b, expected 1 0", data_read, MA_stall);
        end
        @(negedge clk);
        drive_op(32'h904, 3'b010, 32'h5004, $urandom, 4'hF, 1'b1, 1'b0);
        data_resp = 1'b1; data_rdata = w2;
        #1;
        n_checks++;
        if (data_read !== 1'b1 || MA_stall !== 1'b0 || mem_rdata_out !== w1 || PC_out !== 32'h900) begin
            n_fail++; $display("FAIL b2b_second: rd=%b stall=%b rdata=%h pc=%h, expected 1 0 %h 900",
                               data_read, MA_stall, mem_rdata_out, PC_out, w1);
        end
        @(negedge clk);
        data_resp = 1'b0; drive_bubble();
        n_checks++;
        if (mem_rdata_out !== w2 || PC_out !== 32'h904) begin
            n_fail++; $display("FAIL b2b_third: rdata=%h pc=%h, expected %h 904", mem_rdata_out, PC_out, w2);
        end
    endtask

    task automatic test_random(input int n_ops);
        logic [2:0] load_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        for (int i = 0; i < n_ops; i++) begin
            int          kind, lat, hold, req_err;
            logic        rd, wr;
            logic [2:0]  f3;
            logic [31:0] addr, rs2, word, exp_rdata, exp_pc, exp_instr;
            rv32i_control_word exp_ctrl;
            kind = $urandom_range(0, 4);
            rd   = (kind == 1 || kind == 2 || kind == 4);
            wr   = (kind == 3 || kind == 4);
            f3   = wr ? 3'($urandom_range(0, 2)) : load_f3[$urandom_range(0, 4)];
            addr = $urandom; rs2 = $urandom; word = $urandom;
            drive_op($urandom, f3, addr, rs2, 4'($urandom_range(0, 15)), rd, wr);
            exp_pc = PC_in; exp_instr = instruction_in; exp_ctrl = ctrl_word_in;
            exp_rdata = (rd && !wr) ? ref_load(word, int'(addr % 4), f3) : 32'h0;
            stall_in = 1'b0; data_resp = 1'b0; req_err = 0;
            if (!(rd || wr)) begin
                #1;
                if ({data_read, data_write, MA_stall} !== 3'b000) req_err++;
                @(negedge clk);
            end else begin
                lat  = $urandom_range(0, 3);
                hold = $urandom_range(0, 2);
                for (int k = 0; k <= lat; k++) begin
                    data_resp  = (k == lat);
                    data_rdata = (k == lat) ? word : $urandom;
                    stall_in   = (k == lat) && (hold > 0);
                    #1;
                    if (data_read !== (rd && !wr) || data_write !== wr ||
                        data_addr !== (addr & 32'hFFFF_FFFC) || MA_stall !== (k != lat) ||
                        (wr && data_wdata !== (rs2 << (8 * (addr % 4)))))
                        req_err++;
                    @(negedge clk);
                end
                data_resp = 1'b0;
                for (int h = 0; h < hold; h++) begin
                    stall_in = (h != hold - 1); data_rdata = $urandom;
                    #1;
                    if ({data_read, data_write, MA_stall} !== 3'b000) req_err++;
                    @(negedge clk);
                end
            end
            drive_bubble(); stall_in = 1'b0;
            n_checks++;
            if (req_err != 0) begin
                n_fail++; $display("FAIL rand_req[%0d]: %0d bad request cycles, kind=%0d", i, req_err, kind);
            end
            n_checks++;
            if (mem_rdata_out !== exp_rdata) begin
                n_fail++; $display("FAIL rand_rdata[%0d]: got %h, expected %h (f3=%0d addr=%h word=%h)",
                                   i, mem_rdata_out, exp_rdata, f3, addr, word);
            end
            n_checks++;
            if (alu_out !== addr || PC_out !== exp_pc || instruction_out !== exp_instr || ctrl_word_out !== exp_ctrl) begin
                n_fail++; $display("FAIL rand_regs[%0d]: alu=%h pc=%h, expected %h %h", i, alu_out, PC_out, addr, exp_pc);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        data_resp = 1'b0; data_rdata = '0; stall_in = 1'b0; rst = 1'b0;
        drive_bubble();
        test_reset();
        test_lb_wait();
        test_sh_store();
        test_lhu_hold();
        test_alu_op();
        test_reset_mid_access();
        test_back_to_back();
        test_random(60);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
